// File: rtl/dfd_trace_hop_sink.sv
// Trace hop chain sink: buffers one-hot upstream packets, encodes the core index
// for the funnel, and drives backpressure, enabled-source mask and a flush/drain handshake.
module dfd_trace_hop_sink #(
  parameter int NUM_CORES_IN_PATH   = 4,
  parameter int DATA_WIDTH_IN_BYTES = 16,
  parameter int DATA_WIDTH          = DATA_WIDTH_IN_BYTES*8,
  parameter int FIFO_DEPTH          = 16,
  parameter int BP_SKID             = 8,
  parameter int FLUSH_QUIET_CYCLES  = 16
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic [NUM_CORES_IN_PATH-1:0]         upstrm_tr_vld,
  input  logic                                 upstrm_tr_src,
  input  logic [DATA_WIDTH-1:0]                upstrm_tr_data,
  output logic                                 upstrm_tr_ntrace_bp,
  output logic                                 upstrm_tr_dst_bp,
  output logic                                 upstrm_tr_ntrace_flush,
  output logic                                 upstrm_tr_dst_flush,
  output logic [NUM_CORES_IN_PATH-1:0]         upstrm_tr_enabled_srcs,
  input  logic [NUM_CORES_IN_PATH-1:0]         cfg_tr_enabled_srcs,
  output logic                                 funnel_tr_vld,
  input  logic                                 funnel_tr_rdy,
  output logic                                 funnel_tr_src,
  output logic [$clog2(NUM_CORES_IN_PATH)-1:0] funnel_tr_core_id,
  output logic [DATA_WIDTH-1:0]                funnel_tr_data,
  input  logic                                 funnel_ntrace_bp,
  input  logic                                 funnel_dst_bp,
  input  logic                                 funnel_ntrace_flush_req,
  input  logic                                 funnel_dst_flush_req,
  output logic                                 funnel_flush_done,
  output logic [2:0]                           err_sts,
  output logic [15:0]                          err_drop_cnt,
  input  logic                                 err_clr
);

  localparam int CW = $clog2(NUM_CORES_IN_PATH);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0]                  AFULL_TH  = (PW+1)'(FIFO_DEPTH - BP_SKID);
  localparam logic [PW:0]                  FULL_TH   = (PW+1)'(FIFO_DEPTH);
  localparam logic [PW:0]                  CNT_ONE   = (PW+1)'(1);
  localparam logic [PW-1:0]                PTR_ONE   = PW'(1);
  localparam logic [NUM_CORES_IN_PATH-1:0] VLD_ONE   = NUM_CORES_IN_PATH'(1);
  localparam logic [7:0]                   QUIET_MAX = 8'(FLUSH_QUIET_CYCLES);

  typedef struct packed {
    logic                  src;
    logic [CW-1:0]         core_id;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  typedef enum logic [1:0] {ST_IDLE, ST_FLUSH, ST_DRAIN, ST_DONE} st_t;

  entry_t        mem [FIFO_DEPTH];
  entry_t        wr_ent, head;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic [CW-1:0] enc_id;
  logic          push, pop, push_ok, drop, full, empty, afull;
  logic          multi_vld, dis_src;
  st_t           state;
  logic          ntrace_flag, dst_flag;
  logic [7:0]    quiet;

  // Lowest set bit wins when several valids collide.
  always_comb begin
    enc_id = '0;
    for (int i = NUM_CORES_IN_PATH-1; i >= 0; i--)
      if (upstrm_tr_vld[i]) enc_id = CW'(i);
  end

  assign push      = |upstrm_tr_vld;
  assign multi_vld = |(upstrm_tr_vld & (upstrm_tr_vld - VLD_ONE));
  assign dis_src   = |(upstrm_tr_vld & ~upstrm_tr_enabled_srcs);
  assign full      = (count == FULL_TH);
  assign empty     = (count == '0);
  assign afull     = (count >= AFULL_TH);
  assign pop       = funnel_tr_vld & funnel_tr_rdy;
  assign push_ok   = push & (~full | pop);
  assign drop      = push & full & ~pop;

  assign wr_ent = '{src: upstrm_tr_src, core_id: enc_id, data: upstrm_tr_data};
  assign head   = mem[rd_ptr];

  // Head fields are masked so stale storage never leaks out while empty.
  assign funnel_tr_vld     = ~empty;
  assign funnel_tr_src     = funnel_tr_vld & head.src;
  assign funnel_tr_core_id = funnel_tr_vld ? head.core_id : '0;
  assign funnel_tr_data    = funnel_tr_vld ? head.data : '0;

  always_ff @(posedge clk)
    if (push_ok) mem[wr_ptr] <= wr_ent;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
      case ({push_ok, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      upstrm_tr_ntrace_bp    <= 1'b0;
      upstrm_tr_dst_bp       <= 1'b0;
      upstrm_tr_enabled_srcs <= '0;
    end else begin
      upstrm_tr_ntrace_bp    <= afull | funnel_ntrace_bp;
      upstrm_tr_dst_bp       <= afull | funnel_dst_bp;
      upstrm_tr_enabled_srcs <= cfg_tr_enabled_srcs;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_sts      <= '0;
      err_drop_cnt <= '0;
    end else if (err_clr) begin
      err_sts      <= '0;
      err_drop_cnt <= '0;
    end else begin
      err_sts <= err_sts | {drop, dis_src, multi_vld};
      if (drop && err_drop_cnt != 16'hFFFF) err_drop_cnt <= err_drop_cnt + 16'd1;
    end
  end

  // Flush handshake: hold flush toward the hops until upstream has been quiet
  // long enough and everything already buffered has reached the funnel.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state                  <= ST_IDLE;
      ntrace_flag            <= 1'b0;
      dst_flag               <= 1'b0;
      quiet                  <= '0;
      upstrm_tr_ntrace_flush <= 1'b0;
      upstrm_tr_dst_flush    <= 1'b0;
      funnel_flush_done      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          funnel_flush_done <= 1'b0;
          if (funnel_ntrace_flush_req || funnel_dst_flush_req) begin
            ntrace_flag            <= funnel_ntrace_flush_req;
            dst_flag               <= funnel_dst_flush_req;
            upstrm_tr_ntrace_flush <= funnel_ntrace_flush_req;
            upstrm_tr_dst_flush    <= funnel_dst_flush_req;
            state                  <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          upstrm_tr_ntrace_flush <= ntrace_flag;
          upstrm_tr_dst_flush    <= dst_flag;
          quiet                  <= '0;
          state                  <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (push)                  quiet <= '0;
          else if (quiet != 8'hFF)   quiet <= quiet + 8'd1;
          if (quiet == QUIET_MAX && empty) begin
            upstrm_tr_ntrace_flush <= 1'b0;
            upstrm_tr_dst_flush    <= 1'b0;
            funnel_flush_done      <= 1'b1;
            state                  <= ST_DONE;
          end else begin
            upstrm_tr_ntrace_flush <= ntrace_flag;
            upstrm_tr_dst_flush    <= dst_flag;
          end
        end
        default: begin
          funnel_flush_done <= 1'b0;
          ntrace_flag       <= 1'b0;
          dst_flag          <= 1'b0;
          state             <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dfd_trace_hop_sink.sv
// Directed bench for dfd_trace_hop_sink: datapath, fill/overflow, errors, flush FSM, async reset.
module tb_dfd_trace_hop_sink;
  localparam int N  = 4;
  localparam int DW = 128;
  localparam int D  = 16;
  localparam int SK = 8;
  localparam int Q  = 16;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [N-1:0]   upstrm_tr_vld;
  logic           upstrm_tr_src;
  logic [DW-1:0]  upstrm_tr_data;
  logic           upstrm_tr_ntrace_bp, upstrm_tr_dst_bp;
  logic           upstrm_tr_ntrace_flush, upstrm_tr_dst_flush;
  logic [N-1:0]   upstrm_tr_enabled_srcs;
  logic [N-1:0]   cfg_tr_enabled_srcs;
  logic           funnel_tr_vld, funnel_tr_rdy, funnel_tr_src;
  logic [1:0]     funnel_tr_core_id;
  logic [DW-1:0]  funnel_tr_data;
  logic           funnel_ntrace_bp, funnel_dst_bp;
  logic           funnel_ntrace_flush_req, funnel_dst_flush_req;
  logic           funnel_flush_done;
  logic [2:0]     err_sts;
  logic [15:0]    err_drop_cnt;
  logic           err_clr;

  int checks = 0;
  int errors = 0;

  dfd_trace_hop_sink #(
    .NUM_CORES_IN_PATH(N), .DATA_WIDTH_IN_BYTES(DW/8), .DATA_WIDTH(DW),
    .FIFO_DEPTH(D), .BP_SKID(SK), .FLUSH_QUIET_CYCLES(Q)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .upstrm_tr_vld(upstrm_tr_vld), .upstrm_tr_src(upstrm_tr_src), .upstrm_tr_data(upstrm_tr_data),
    .upstrm_tr_ntrace_bp(upstrm_tr_ntrace_bp), .upstrm_tr_dst_bp(upstrm_tr_dst_bp),
    .upstrm_tr_ntrace_flush(upstrm_tr_ntrace_flush), .upstrm_tr_dst_flush(upstrm_tr_dst_flush),
    .upstrm_tr_enabled_srcs(upstrm_tr_enabled_srcs), .cfg_tr_enabled_srcs(cfg_tr_enabled_srcs),
    .funnel_tr_vld(funnel_tr_vld), .funnel_tr_rdy(funnel_tr_rdy), .funnel_tr_src(funnel_tr_src),
    .funnel_tr_core_id(funnel_tr_core_id), .funnel_tr_data(funnel_tr_data),
    .funnel_ntrace_bp(funnel_ntrace_bp), .funnel_dst_bp(funnel_dst_bp),
    .funnel_ntrace_flush_req(funnel_ntrace_flush_req), .funnel_dst_flush_req(funnel_dst_flush_req),
    .funnel_flush_done(funnel_flush_done), .err_sts(err_sts), .err_drop_cnt(err_drop_cnt),
    .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] all_outs();
    return {funnel_tr_vld, upstrm_tr_ntrace_bp, upstrm_tr_dst_bp, upstrm_tr_ntrace_flush,
            upstrm_tr_dst_flush, upstrm_tr_enabled_srcs, funnel_tr_src, funnel_tr_core_id,
            funnel_tr_data, funnel_flush_done, err_sts, err_drop_cnt};
  endfunction

  initial begin
    logic [DW-1:0] pat;
    logic early_done, flush_lost;
    int pulses, first_n;

    reset_n = 1'b0; upstrm_tr_vld = '0; upstrm_tr_src = 1'b0; upstrm_tr_data = '0;
    cfg_tr_enabled_srcs = '0; funnel_tr_rdy = 1'b0; funnel_ntrace_bp = 1'b0; funnel_dst_bp = 1'b0;
    funnel_ntrace_flush_req = 1'b0; funnel_dst_flush_req = 1'b0; err_clr = 1'b0;
    #12;
    chk("reset_outs", all_outs(), '0);
    reset_n = 1'b1;
    cfg_tr_enabled_srcs = 4'hF;
    step();
    chk("enabled_srcs", upstrm_tr_enabled_srcs, 4'hF);

    // Single packet
    pat = {16{8'hA5}};
    upstrm_tr_vld = 4'b0100; upstrm_tr_src = 1'b1; upstrm_tr_data = pat;
    step();
    upstrm_tr_vld = '0; upstrm_tr_src = 1'b0;
    chk("single_vld", funnel_tr_vld, 1'b1);
    chk("single_core", funnel_tr_core_id, 2'd2);
    chk("single_src", funnel_tr_src, 1'b1);
    chk("single_data", funnel_tr_data, pat);
    funnel_tr_rdy = 1'b1;
    step();
    funnel_tr_rdy = 1'b0;
    chk("single_empty", funnel_tr_vld, 1'b0);

    // Fill to full with the funnel stalled
    for (int i = 0; i < D; i++) begin
      upstrm_tr_vld = 4'b0001; upstrm_tr_data = DW'(i);
      step();
      if (i == 7) chk("bp_lag", {upstrm_tr_ntrace_bp, upstrm_tr_dst_bp}, 2'b00);
      if (i == 8) chk("bp_afull", {upstrm_tr_ntrace_bp, upstrm_tr_dst_bp}, 2'b11);
    end
    upstrm_tr_data = DW'(32'hDEAD);
    step();
    chk("ovf_err", err_sts, 3'b100);
    chk("ovf_cnt", err_drop_cnt, 16'd1);
    upstrm_tr_data = DW'(8'h77); funnel_tr_rdy = 1'b1;
    step();
    upstrm_tr_vld = '0; funnel_tr_rdy = 1'b0;
    chk("full_pp_cnt", err_drop_cnt, 16'd1);
    chk("full_pp_head", funnel_tr_data, DW'(1));
    funnel_tr_rdy = 1'b1;
    for (int i = 0; i < 15; i++) step();
    chk("full_pp_tail", funnel_tr_data, DW'(8'h77));
    step();
    funnel_tr_rdy = 1'b0;
    chk("drained", funnel_tr_vld, 1'b0);

    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("clr_cnt", {err_sts, err_drop_cnt}, '0);

    // Error flags
    upstrm_tr_vld = 4'b0110; upstrm_tr_data = DW'(5);
    step();
    upstrm_tr_vld = '0;
    chk("multi_err", err_sts, 3'b001);
    chk("multi_core", funnel_tr_core_id, 2'd1);
    funnel_tr_rdy = 1'b1;
    step();
    funnel_tr_rdy = 1'b0;
    cfg_tr_enabled_srcs = 4'b1011;
    step();
    upstrm_tr_vld = 4'b0100;
    step();
    upstrm_tr_vld = '0;
    chk("dis_err", err_sts, 3'b011);
    err_clr = 1'b1; upstrm_tr_vld = 4'b0110;
    step();
    err_clr = 1'b0; upstrm_tr_vld = '0;
    chk("clr_prio", {err_sts, err_drop_cnt}, '0);
    funnel_tr_rdy = 1'b1;
    step(); step();
    cfg_tr_enabled_srcs = 4'hF;
    step();

    // ntrace flush with sparse traffic; rdy stays high
    funnel_ntrace_flush_req = 1'b1;
    step();
    funnel_ntrace_flush_req = 1'b0;
    chk("nt_flush_sel", {upstrm_tr_ntrace_flush, upstrm_tr_dst_flush}, 2'b10);
    early_done = 1'b0; flush_lost = 1'b0;
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 4; j++) begin
        step();
        early_done |= funnel_flush_done;
      end
      upstrm_tr_vld = 4'b0001;
      step();
      upstrm_tr_vld = '0;
      early_done |= funnel_flush_done;
    end
    for (int i = 1; i <= Q + 1; i++) begin
      step();
      if (i <= Q) begin
        early_done |= funnel_flush_done;
        flush_lost |= ~upstrm_tr_ntrace_flush;
      end
    end
    chk("nt_no_early", early_done, 1'b0);
    chk("nt_flush_held", flush_lost, 1'b0);
    chk("nt_done", {funnel_flush_done, upstrm_tr_ntrace_flush}, 2'b10);
    step();
    chk("nt_done_pulse", funnel_flush_done, 1'b0);

    // Simultaneous requests, extra request during DRAIN
    funnel_ntrace_flush_req = 1'b1; funnel_dst_flush_req = 1'b1;
    step();
    funnel_ntrace_flush_req = 1'b0; funnel_dst_flush_req = 1'b0;
    chk("both_flush", {upstrm_tr_ntrace_flush, upstrm_tr_dst_flush}, 2'b11);
    pulses = 0; first_n = 0;
    for (int n = 1; n <= 40; n++) begin
      funnel_ntrace_flush_req = (n == 2);
      step();
      if (funnel_flush_done) begin
        pulses++;
        if (first_n == 0) first_n = n;
      end
    end
    funnel_ntrace_flush_req = 1'b0;
    chk("both_pulses", pulses, 1);
    chk("both_latency", first_n, Q + 2);

    // Reset during DRAIN with 5 buffered entries
    funnel_tr_rdy = 1'b0;
    funnel_dst_flush_req = 1'b1;
    step();
    funnel_dst_flush_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      upstrm_tr_vld = 4'b0010; upstrm_tr_data = DW'(i + 100);
      step();
    end
    upstrm_tr_vld = '0;
    chk("pre_rst", {funnel_tr_vld, upstrm_tr_dst_flush}, 2'b11);
    reset_n = 1'b0;
    #1;
    chk("rst_async_outs", all_outs(), '0);
    #2;
    reset_n = 1'b1;
    step();
    chk("post_rst", {funnel_tr_vld, upstrm_tr_ntrace_flush, upstrm_tr_dst_flush}, 3'b000);
    funnel_ntrace_flush_req = 1'b1;
    step();
    funnel_ntrace_flush_req = 1'b0;
    chk("post_rst_idle", {upstrm_tr_ntrace_flush, upstrm_tr_dst_flush}, 2'b10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
